trbg_word_collector: RTL and testbench

//  Parametrised successor to the single-pair TRBG datapath. Takes N_CH raw entropy bits from free-running oscillator samplers
//  and XOR-combines them into one raw bit per sample strobe.

---
 rtl/trbg_word_collector.sv | 192 +++++++++++++++++++
 tb/tb_trbg_word_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trbg_word_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trbg_word_collector                                           |
// | Purpose  : XOR-combines N_CH synchronised entropy bits, applies a        |
// |            repetition-count health test, and packs accepted bits into    |
// |            OUT_W-bit words on a valid/ready output.                      |
// | Options  : TRBG_VN_DEBIAS_EN enables von Neumann debiasing of samples.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module trbg_word_collector #(
  parameter int N_CH      = 2,
  parameter int OUT_W     = 8,
  parameter int RCT_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             sample_en,
  input  logic [N_CH-1:0]  raw_in,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             overrun,
  output logic             health_fail
);

  localparam int c_cnt_w = $clog2(OUT_W);
  localparam int c_rct_w = $clog2(RCT_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(OUT_W - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_rct_w-1:0] c_rct_one  = c_rct_w'(1);
  localparam logic [c_rct_w-1:0] c_rct_max  = c_rct_w'(RCT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t             r_state;
  logic [N_CH-1:0]    r_sync1;
  logic [N_CH-1:0]    r_sync2;
  logic [OUT_W-1:0]   r_sr;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [c_rct_w-1:0] r_rct_cnt;
  logic               r_prev_bit;
  logic [OUT_W-1:0]   r_rnd_data;
  logic               r_rnd_valid;
  logic               r_overrun;
  logic               r_health_fail;

  logic               w_raw_bit;
  logic               w_sample;
  logic               w_handshake;
  logic               w_out_free;
  logic [c_rct_w-1:0] w_rct_next;
  logic               w_rct_trip;
  logic               w_acc;
  logic               w_acc_bit;
  logic [OUT_W-1:0]   w_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw_bit   = ^r_sync2;
  assign w_sample    = ena && sample_en && (r_state != S_FAIL);
  assign w_handshake = r_rnd_valid && rnd_ready;
  assign w_out_free  = !r_rnd_valid || rnd_ready;
  // A zero count marks the first sample after IDLE, which always starts a new run.
  assign w_rct_next  = ((r_rct_cnt != '0) && (w_raw_bit == r_prev_bit)) ? (r_rct_cnt + c_rct_one) : c_rct_one;
  assign w_rct_trip  = w_sample && (w_rct_next == c_rct_max);
  assign w_word      = {r_sr[OUT_W-2:0], w_acc_bit};

`ifdef TRBG_VN_DEBIAS_EN
  logic r_vn_have;
  logic r_vn_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (!ena || (r_state == S_FAIL) || w_rct_trip) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (w_sample) begin
      r_vn_have <= !r_vn_have;
      if (!r_vn_have) begin
        r_vn_first <= w_raw_bit;
      end
    end
  end

  // Pair 01 yields 0 and 10 yields 1, i.e. the first sample of an unequal pair.
  assign w_acc     = w_sample && r_vn_have && (r_vn_first != w_raw_bit);
  assign w_acc_bit = r_vn_first;
`else
  assign w_acc     = w_sample;
  assign w_acc_bit = w_raw_bit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_rct_cnt     <= '0;
      r_prev_bit    <= 1'b0;
      r_rnd_data    <= '0;
      r_rnd_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_health_fail <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_state == S_FAIL) begin
        r_sr        <= '0;
        r_bit_cnt   <= '0;
        r_rct_cnt   <= '0;
        r_rnd_data  <= '0;
        r_rnd_valid <= 1'b0;
      end else if (!ena) begin
        r_state   <= S_IDLE;
        r_sr      <= '0;
        r_bit_cnt <= '0;
        r_rct_cnt <= '0;
        if (w_handshake) begin
          r_rnd_valid <= 1'b0;
        end
      end else if (w_rct_trip) begin
        // Health failure overrides any word completing on the same edge.
        r_state       <= S_FAIL;
        r_health_fail <= 1'b1;
        r_sr          <= '0;
        r_bit_cnt     <= '0;
        r_rct_cnt     <= '0;
        r_rnd_data    <= '0;
        r_rnd_valid   <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rct_cnt  <= w_rct_next;
          r_prev_bit <= w_raw_bit;
        end
        if (r_state == S_FULL) begin
          if (w_acc) begin
            r_overrun <= 1'b1;
          end
          if (w_handshake) begin
            r_rnd_data <= r_sr;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_FILL;
          end
        end else begin
          r_state <= S_FILL;
          if (w_handshake) begin
            r_rnd_valid <= 1'b0;
          end
          if (w_acc) begin
            if (r_bit_cnt == c_last_bit) begin
              r_bit_cnt <= '0;
              if (w_out_free) begin
                r_rnd_data  <= w_word;
                r_rnd_valid <= 1'b1;
                r_sr        <= '0;
              end else begin
                r_sr    <= w_word;
                r_state <= S_FULL;
              end
            end else begin
              r_sr      <= w_word;
              r_bit_cnt <= r_bit_cnt + c_cnt_one;
            end
          end
        end
      end
    end
  end

  assign rnd_data    = r_rnd_data;
  assign rnd_valid   = r_rnd_valid;
  assign overrun     = r_overrun;
  assign health_fail = r_health_fail;

endmodule
`default_nettype wire

// File: tb/tb_trbg_word_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trbg_word_collector                                        |
// | Purpose  : Self-checking bench for trbg_word_collector against a         |
// |            queue-based reference model (TRBG_VN_DEBIAS_EN aware).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_trbg_word_collector;

  localparam int N_CH  = 2;
  localparam int OUT_W = 8;
  localparam int RCT   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             ena = 1'b0;
  logic             sample_en = 1'b0;
  logic [N_CH-1:0]  raw_in = '0;
  logic [OUT_W-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready = 1'b0;
  logic             overrun;
  logic             health_fail;

  int n_assert = 0;
  int n_fail   = 0;
  int ov_seen  = 0;

  // Reference model state
  logic [N_CH-1:0]  m_s1, m_s2;
  int               m_run;
  bit               m_prev;
  bit               m_bits[$];
  bit               m_pair[$];
  bit               m_held;
  logic [OUT_W-1:0] m_held_word;
  bit               m_valid, m_ov, m_hf, m_fail;
  logic [OUT_W-1:0] m_data;

  bit exp_bits[$];
  bit tb_last, r_bit, ch1;
  int tb_run;
  logic [OUT_W-1:0] exp_w;

  trbg_word_collector #(.N_CH(N_CH), .OUT_W(OUT_W), .RCT_LIMIT(RCT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .sample_en  (sample_en),
    .raw_in     (raw_in),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .overrun    (overrun),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] pack(input bit q[$], input int start);
    logic [OUT_W-1:0] w = '0;
    for (int i = 0; i < OUT_W; i++) w = {w[OUT_W-2:0], q[start+i]};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_run = 0; m_prev = 0;
    m_bits.delete(); m_pair.delete();
    m_held = 0; m_held_word = '0;
    m_valid = 0; m_data = '0; m_ov = 0; m_hf = 0; m_fail = 0;
  endtask

  // One rising edge of the collector, computed from the pre-edge inputs.
  task automatic model_step();
    bit raw, smp, hs, free, trip, acc, ab, f;
    raw  = ^m_s2;
    smp  = ena && sample_en && !m_fail;
    hs   = m_valid && rnd_ready;
    free = !m_valid || rnd_ready;
    trip = 0; acc = 0; ab = 0;
    m_ov = 0;
    if (!m_fail) begin
      if (!ena) begin
        m_run = 0; m_bits.delete(); m_pair.delete(); m_held = 0;
        if (hs) m_valid = 0;
      end else begin
        if (smp) begin
          m_run  = (m_run != 0 && raw == m_prev) ? m_run + 1 : 1;
          m_prev = raw;
          trip   = (m_run == RCT);
`ifdef TRBG_VN_DEBIAS_EN
          if (m_pair.size() == 0) m_pair.push_back(raw);
          else begin
            f = m_pair.pop_front();
            if (f != raw) begin acc = 1; ab = f; end
          end
`else
          acc = 1; ab = raw;
`endif
        end
        if (trip) begin
          m_fail = 1; m_hf = 1; m_valid = 0; m_data = '0;
          m_bits.delete(); m_pair.delete(); m_held = 0;
        end else if (m_held) begin
          if (acc) m_ov = 1;
          if (hs) begin m_data = m_held_word; m_held = 0; end
        end else begin
          if (hs) m_valid = 0;
          if (acc) m_bits.push_back(ab);
          if (m_bits.size() == OUT_W) begin
            if (free) begin m_data = pack(m_bits, 0); m_valid = 1; end
            else begin m_held_word = pack(m_bits, 0); m_held = 1; end
            m_bits.delete();
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("rnd_valid", rnd_valid, m_valid);
    chk("rnd_data", rnd_data, m_data);
    chk("overrun", overrun, m_ov);
    chk("health_fail", health_fail, m_hf);
    if (overrun === 1'b1) ov_seen++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_valid", rnd_valid, 0);
    chk("rst_data", rnd_data, 0);
    chk("rst_health", health_fail, 0);
    chk("rst_overrun", overrun, 0);
    model_clear();
    ena = 1'b0; sample_en = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Holds raw_in long enough to cross the synchroniser, then samples once.
  task automatic put_bit(input logic [N_CH-1:0] v);
    raw_in = v; sample_en = 1'b0;
    cycle(); cycle();
    sample_en = 1'b1;
    cycle();
    sample_en = 1'b0;
  endtask

  initial begin
    #1 do_reset();
    cycle();

    // Directed word B2 with ready high
    ena = 1'b1; rnd_ready = 1'b1;
    foreach (exp_bits[i]) exp_bits.delete();
    exp_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    foreach (exp_bits[i]) put_bit({1'b0, exp_bits[i]});
`ifndef TRBG_VN_DEBIAS_EN
    chk("t2_valid", rnd_valid, 1);
    chk("t2_data", rnd_data, 8'hB2);
    cycle();
    chk("t2_valid_drop", rnd_valid, 0);
`endif

    // Partial word discarded by ena low, then alternating word AA
    ena = 1'b0; cycle(); ena = 1'b1;
    exp_bits = '{1, 1, 0, 0, 1};
    foreach (exp_bits[i]) put_bit({1'b0, exp_bits[i]});
    ena = 1'b0; cycle(); ena = 1'b1;
    rnd_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_bit({1'b0, (i % 2 == 0)});
`ifndef TRBG_VN_DEBIAS_EN
    chk("t6_valid", rnd_valid, 1);
    chk("t6_data", rnd_data, 8'hAA);
`endif

    // Asynchronous reset while a word is pending
    do_reset();
    cycle();

    // Health test: eight identical raw bits
    ena = 1'b1;
    for (int i = 0; i < 7; i++) put_bit(2'b11);
    chk("t3_hf_before", health_fail, 0);
    put_bit(2'b11);
    chk("t3_hf", health_fail, 1);
    chk("t3_valid", rnd_valid, 0);
    rnd_ready = 1'b1;
    for (int i = 0; i < 9; i++) put_bit({1'b0, i[0]});
    chk("t3_no_words", rnd_valid, 0);
    do_reset();

    // Back-pressure: 24 samples with ready low
    ena = 1'b1; rnd_ready = 1'b0;
    exp_bits.delete(); tb_run = 0; tb_last = 0; ov_seen = 0;
    for (int i = 0; i < 24; i++) begin
      r_bit = 1'($urandom);
      if (tb_run >= 3 && r_bit == tb_last) r_bit = ~r_bit;
      tb_run  = (tb_run != 0 && r_bit == tb_last) ? tb_run + 1 : 1;
      tb_last = r_bit;
      ch1 = 1'($urandom);
      exp_bits.push_back(r_bit);
      put_bit({ch1, ch1 ^ r_bit});
    end
`ifndef TRBG_VN_DEBIAS_EN
    chk("t4_overruns", ov_seen, 8);
    exp_w = pack(exp_bits, 0);
    chk("t4_word1", rnd_data, exp_w);
    chk("t4_valid1", rnd_valid, 1);
`endif
    rnd_ready = 1'b1;
    cycle();
`ifndef TRBG_VN_DEBIAS_EN
    exp_w = pack(exp_bits, 8);
    chk("t4_word2", rnd_data, exp_w);
    chk("t4_valid2", rnd_valid, 1);
`endif
    cycle();
`ifndef TRBG_VN_DEBIAS_EN
    chk("t4_drained", rnd_valid, 0);
`endif

`ifdef TRBG_VN_DEBIAS_EN
    // Debias: pairs 01,00,10,11 repeated four times give 0,1 x4
    ena = 1'b0; cycle(); ena = 1'b1;
    exp_bits = '{0, 1, 0, 0, 1, 0, 1, 1};
    for (int k = 0; k < 4; k++)
      foreach (exp_bits[i]) put_bit({1'b0, exp_bits[i]});
    chk("t5_valid", rnd_valid, 1);
    chk("t5_data", rnd_data, 8'h55);
`endif

    // Randomised segments with varying back-pressure
    for (int s = 0; s < 5; s++) begin
      do_reset();
      for (int c = 0; c < 90; c++) begin
        ena       = ($urandom_range(0, 19) != 0);
        sample_en = ($urandom_range(0, 2) != 0);
        raw_in    = N_CH'($urandom);
        rnd_ready = (s % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
